alu_sequencer: RTL and testbench

- Initiator-side control block for the 16-bit ALU. Accepts 16-bit instruction words over a valid/ready handshake and drives the ALU control inputs (a, b, sub, op_select, load, reg_select).
- Samples the ALU result and flags after a programmable settle time, then returns exactly one response per instruction over a second valid/ready handshake.
- Sits between an instruction source (FIFO or fetch logic) and the ALU, replacing hand-driven bench stimulus.

---
 rtl/alu_pkg.sv | 59 +++++
 rtl/alu_instr_decode.sv | 36 +++
 rtl/alu_sequencer.sv | 194 +++++++++++++++++++
 tb/tb_alu_sequencer.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : alu_pkg
// Description : Shared constants, state encoding and helpers for the ALU
//               instruction sequencer and its instruction decoder.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

  // Instruction word layout
  localparam int INSTR_W   = 16;
  localparam int LOAD_BIT  = 15;  // 1 = LOAD, 0 = EXEC
  localparam int FIELD_LSB = 12;  // reg_select (LOAD) / op_select (EXEC)
  localparam int FIELD_W   = 3;
  localparam int IMM_LSB   = 0;   // LOAD immediate
  localparam int IMM_W     = 12;

  // EXEC opcodes; 3'd6 and 3'd7 are illegal
  localparam logic [FIELD_W-1:0] OP_ADD = 3'd0;
  localparam logic [FIELD_W-1:0] OP_SUB = 3'd1;
  localparam logic [FIELD_W-1:0] OP_AND = 3'd2;
  localparam logic [FIELD_W-1:0] OP_OR  = 3'd3;
  localparam logic [FIELD_W-1:0] OP_MUL = 3'd4;
  localparam logic [FIELD_W-1:0] OP_DIV = 3'd5;

  // Sequencer states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    EXEC = 2'd2,
    RESP = 2'd3
  } state_t;

  // Response flag bit order: {cout, overflow, NO, ZO}
  localparam int FLAGS_W   = 4;
  localparam int FLAG_COUT = 3;
  localparam int FLAG_OVF  = 2;
  localparam int FLAG_NO   = 1;
  localparam int FLAG_ZO   = 0;

  // Pack the individual ALU flags into response bit order
  function automatic logic [FLAGS_W-1:0] pack_flags(
    input logic cout,
    input logic ovf,
    input logic neg,
    input logic zero
  );
    logic [FLAGS_W-1:0] f;
    f            = '0;
    f[FLAG_COUT] = cout;
    f[FLAG_OVF]  = ovf;
    f[FLAG_NO]   = neg;
    f[FLAG_ZO]   = zero;
    return f;
  endfunction

endpackage : alu_pkg
`default_nettype wire

// File: rtl/alu_instr_decode.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : alu_instr_decode
// Description : Purely combinational split of a 16-bit instruction word into
//               LOAD/EXEC fields, with illegal-opcode and subtract detection.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_instr_decode
  import alu_pkg::*;
(
  input  logic [INSTR_W-1:0] instr_i,
  output logic               is_load_o,
  output logic [FIELD_W-1:0] reg_sel_o,
  output logic [IMM_W-1:0]   imm_o,
  output logic [FIELD_W-1:0] op_o,
  output logic               illegal_o,
  output logic               sub_o
);

  // Field extraction; op/illegal/sub only qualify EXEC words
  always_comb begin
    is_load_o = instr_i[LOAD_BIT];
    reg_sel_o = instr_i[FIELD_LSB +: FIELD_W];
    imm_o     = instr_i[IMM_LSB +: IMM_W];
    op_o      = instr_i[FIELD_LSB +: FIELD_W];
    illegal_o = 1'b0;
    sub_o     = 1'b0;
    if (!is_load_o) begin
      illegal_o = (op_o > OP_DIV);
      sub_o     = (op_o == OP_SUB);
    end
  end

endmodule : alu_instr_decode
`default_nettype wire

// File: rtl/alu_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : alu_sequencer
// Description : Accepts LOAD/EXEC instruction words over valid/ready, drives
//               the ALU control inputs, captures result and flags after a
//               settle time and returns one response per instruction.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_sequencer
  import alu_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2,   // 1..15
  parameter int DATA_W        = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  // instruction channel
  input  logic                instr_valid,
  output logic                instr_ready,
  input  logic [INSTR_W-1:0]  instr_data,
  // ALU control
  output logic [DATA_W-1:0]   alu_a,
  output logic [DATA_W-1:0]   alu_b,
  output logic                alu_sub,
  output logic [FIELD_W-1:0]  alu_op_select,
  output logic                alu_load,
  output logic [FIELD_W-1:0]  alu_reg_select,
  // ALU status
  input  logic [DATA_W-1:0]   alu_result,
  input  logic                alu_cout,
  input  logic                alu_overflow,
  input  logic                alu_no,
  input  logic                alu_zo,
  // response channel
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DATA_W-1:0]   rsp_result,
  output logic [FLAGS_W-1:0]  rsp_flags,
  output logic                rsp_err,
  output logic                busy
);

  localparam logic [3:0] LAST_CNT = 4'(SETTLE_CYCLES - 1);

  // Decoder outputs
  logic               dec_is_load;
  logic [FIELD_W-1:0] dec_reg_sel;
  logic [IMM_W-1:0]   dec_imm;
  logic [FIELD_W-1:0] dec_op;
  logic               dec_illegal;
  logic               dec_sub;

  // State and registered control/response
  state_t              state_q, state_d;
  logic                init_q;
  logic [3:0]          cnt_q, cnt_d;
  logic [DATA_W-1:0]   a_q, a_d;
  logic [FIELD_W-1:0]  reg_sel_q, reg_sel_d;
  logic [FIELD_W-1:0]  op_sel_q, op_sel_d;
  logic                sub_q, sub_d;
  logic [DATA_W-1:0]   result_q, result_d;
  logic [FLAGS_W-1:0]  flags_q, flags_d;
  logic                err_q, err_d;
  logic                accept;

  alu_instr_decode u_decode (
    .instr_i   (instr_data),
    .is_load_o (dec_is_load),
    .reg_sel_o (dec_reg_sel),
    .imm_o     (dec_imm),
    .op_o      (dec_op),
    .illegal_o (dec_illegal),
    .sub_o     (dec_sub)
  );

  assign accept = instr_valid && instr_ready;

  // Ready is withheld until the first clock after reset release
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      init_q <= 1'b0;
    end else begin
      init_q <= 1'b1;
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state plus next values of control, counter and response registers
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    a_d       = a_q;
    reg_sel_d = reg_sel_q;
    op_sel_d  = op_sel_q;
    sub_d     = sub_q;
    result_d  = result_q;
    flags_d   = flags_q;
    err_d     = err_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (dec_is_load) begin
            a_d       = {{(DATA_W-IMM_W){1'b0}}, dec_imm};
            reg_sel_d = dec_reg_sel;
            state_d   = LOAD;
          end else if (dec_illegal) begin
            // op_select keeps the last legal EXEC value
            result_d = '0;
            flags_d  = '0;
            err_d    = 1'b1;
            state_d  = RESP;
          end else begin
            op_sel_d = dec_op;
            sub_d    = dec_sub;
            cnt_d    = 4'd0;
            state_d  = EXEC;
          end
        end
      end
      LOAD: begin
        result_d = a_q;
        flags_d  = '0;
        err_d    = 1'b0;
        state_d  = RESP;
      end
      EXEC: begin
        if (cnt_q == LAST_CNT) begin
          result_d = alu_result;
          flags_d  = pack_flags(alu_cout, alu_overflow, alu_no, alu_zo);
          err_d    = 1'b0;
          state_d  = RESP;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Control, counter and response registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= 4'd0;
      a_q       <= '0;
      reg_sel_q <= '0;
      op_sel_q  <= '0;
      sub_q     <= 1'b0;
      result_q  <= '0;
      flags_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      a_q       <= a_d;
      reg_sel_q <= reg_sel_d;
      op_sel_q  <= op_sel_d;
      sub_q     <= sub_d;
      result_q  <= result_d;
      flags_q   <= flags_d;
      err_q     <= err_d;
    end
  end

  // Strobes decode straight from state so reset clears them without a clock
  assign instr_ready    = init_q && (state_q == IDLE);
  assign busy           = (state_q != IDLE);
  assign alu_load       = (state_q == LOAD);
  assign alu_sub        = sub_q && (state_q == EXEC);
  assign rsp_valid      = (state_q == RESP);
  assign alu_a          = a_q;
  assign alu_b          = '0;
  assign alu_reg_select = reg_sel_q;
  assign alu_op_select  = op_sel_q;
  assign rsp_result     = result_q;
  assign rsp_flags      = flags_q;
  assign rsp_err        = err_q;

endmodule : alu_sequencer
`default_nettype wire

// File: tb/tb_alu_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_alu_sequencer
// Description : Self-checking bench for alu_sequencer with a behavioural
//               16-bit ALU whose operands are register-file entries r0/r1.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_sequencer;

  localparam int SETTLE   = 2;
  localparam int EXEC_LAT = SETTLE + 1;

  logic        clk         = 1'b0;
  logic        rst_n       = 1'b0;
  logic        instr_valid = 1'b0;
  logic        rsp_ready   = 1'b1;
  logic [15:0] instr_data  = 16'h0000;

  logic        instr_ready;
  logic [15:0] alu_a;
  logic [15:0] alu_b;
  logic        alu_sub;
  logic [2:0]  alu_op_select;
  logic        alu_load;
  logic [2:0]  alu_reg_select;
  logic [15:0] alu_result;
  logic        alu_cout;
  logic        alu_overflow;
  logic        alu_no;
  logic        alu_zo;
  logic        rsp_valid;
  logic [15:0] rsp_result;
  logic [3:0]  rsp_flags;
  logic        rsp_err;
  logic        busy;

  alu_sequencer #(
    .SETTLE_CYCLES (SETTLE),
    .DATA_W        (16)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr_data     (instr_data),
    .alu_a          (alu_a),
    .alu_b          (alu_b),
    .alu_sub        (alu_sub),
    .alu_op_select  (alu_op_select),
    .alu_load       (alu_load),
    .alu_reg_select (alu_reg_select),
    .alu_result     (alu_result),
    .alu_cout       (alu_cout),
    .alu_overflow   (alu_overflow),
    .alu_no         (alu_no),
    .alu_zo         (alu_zo),
    .rsp_valid      (rsp_valid),
    .rsp_ready      (rsp_ready),
    .rsp_result     (rsp_result),
    .rsp_flags      (rsp_flags),
    .rsp_err        (rsp_err),
    .busy           (busy)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural ALU: register file + datapath ----------------
  logic [15:0] rf [0:7] = '{default: 16'h0000};
  logic [15:0] m_a, m_b, m_bb;
  logic [16:0] m_s;
  logic [31:0] m_p;

  always @(posedge clk) begin
    if (alu_load) rf[alu_reg_select] <= alu_a;
  end

  always_comb begin
    m_a          = rf[0];
    m_b          = rf[1];
    m_bb         = alu_sub ? ~m_b : m_b;
    m_s          = {1'b0, m_a} + {1'b0, m_bb} + {16'h0000, alu_sub};
    m_p          = {16'h0000, m_a} * {16'h0000, m_b};
    alu_result   = 16'h0000;
    alu_cout     = 1'b0;
    alu_overflow = 1'b0;
    case (alu_op_select)
      3'd0, 3'd1: begin
        alu_result   = m_s[15:0];
        alu_cout     = m_s[16];
        alu_overflow = (m_a[15] == m_bb[15]) && (m_s[15] != m_a[15]);
      end
      3'd2:    alu_result = m_a & m_b;
      3'd3:    alu_result = m_a | m_b;
      3'd4:    alu_result = m_p[15:0];
      3'd5:    alu_result = (m_b == 16'h0000) ? 16'hFFFF : m_a / m_b;
      default: alu_result = 16'h0000;
    endcase
    alu_no = alu_result[15];
    alu_zo = (alu_result == 16'h0000);
  end

  // ---------------- checking infrastructure ----------------
  int n_cmp  = 0;
  int n_fail = 0;

  typedef struct packed {
    logic [15:0] res;
    logic [3:0]  flags;
    logic        err;
  } exp_t;

  exp_t sb[$];

  typedef struct {
    logic [15:0] instr;
    int          lat;
    logic [15:0] res;
    logic [3:0]  flags;
    logic        err;
  } vec_t;

  vec_t tbl[$];

  logic [63:0] outs;
  assign outs = {instr_ready, alu_a, alu_b, alu_sub, alu_op_select, alu_load,
                 alu_reg_select, rsp_valid, rsp_result, rsp_flags, rsp_err, busy};

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Scoreboard: compare every response at its handshake against the oldest expectation
  always @(negedge clk) begin : mon
    exp_t e;
    if (rst_n && rsp_valid && rsp_ready) begin
      if (sb.size() == 0) begin
        check("unexpected_rsp", 64'(1), 64'(0));
      end else begin
        e = sb.pop_front();
        check("rsp_result", 64'(rsp_result), 64'(e.res));
        check("rsp_flags",  64'(rsp_flags),  64'(e.flags));
        check("rsp_err",    64'(rsp_err),    64'(e.err));
      end
    end
  end

  // Present one instruction, push its expectation, and check control and latency
  task automatic send(input logic [15:0] instr, input int exp_lat,
                      input logic [15:0] er, input logic [3:0] ef, input logic ee);
    int w;
    int lat;
    int loads;
    logic is_ld;
    logic [2:0] op;
    exp_t e;
    is_ld = instr[15];
    op    = instr[14:12];
    @(negedge clk);
    instr_data  = instr;
    instr_valid = 1'b1;
    w = 0;
    while (!instr_ready && w < 100) begin
      @(negedge clk);
      w++;
    end
    check("accept_wait", 64'(instr_ready), 64'(1));
    e.res   = er;
    e.flags = ef;
    e.err   = ee;
    sb.push_back(e);
    @(posedge clk);
    #1;
    instr_valid = 1'b0;
    lat   = 1;
    loads = 0;
    while (!rsp_valid && lat < 40) begin
      if (alu_load) begin
        loads++;
        check("load_a",      64'(alu_a),          64'({4'h0, instr[11:0]}));
        check("load_regsel", 64'(alu_reg_select), 64'(instr[14:12]));
      end else if (!is_ld) begin
        check("exec_op",  64'(alu_op_select), 64'(op));
        check("exec_sub", 64'(alu_sub),       64'(op == 3'd1));
      end
      @(posedge clk);
      #1;
      lat++;
    end
    check("latency",      64'(lat),      64'(exp_lat));
    check("load_pulses",  64'(loads),    64'(is_ld ? 1 : 0));
    check("load_in_resp", 64'(alu_load), 64'(0));
  endtask

  task automatic wait_idle();
    int w;
    w = 0;
    while (busy && w < 100) begin
      @(posedge clk);
      #1;
      w++;
    end
    check("idle_wait",       64'(busy),        64'(0));
    check("ready_after_rsp", 64'(instr_ready), 64'(1));
  endtask

  task automatic start_no_push(input logic [15:0] instr);
    int w;
    @(negedge clk);
    instr_data  = instr;
    instr_valid = 1'b1;
    w = 0;
    while (!instr_ready && w < 100) begin
      @(negedge clk);
      w++;
    end
    check("accept_wait", 64'(instr_ready), 64'(1));
    @(posedge clk);
    #1;
    instr_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl.push_back('{16'h8010, 2,        16'h0010, 4'b0000, 1'b0}); // r0=0x010
    tbl.push_back('{16'h9020, 2,        16'h0020, 4'b0000, 1'b0}); // r1=0x020
    tbl.push_back('{16'h0000, EXEC_LAT, 16'h0030, 4'b0000, 1'b0}); // ADD
    tbl.push_back('{16'h1000, EXEC_LAT, 16'hFFF0, 4'b0010, 1'b0}); // SUB -> negative
    tbl.push_back('{16'h2000, EXEC_LAT, 16'h0000, 4'b0001, 1'b0}); // AND -> zero
    tbl.push_back('{16'h3000, EXEC_LAT, 16'h0030, 4'b0000, 1'b0}); // OR
    tbl.push_back('{16'h4000, EXEC_LAT, 16'h0200, 4'b0000, 1'b0}); // MUL
    tbl.push_back('{16'h6000, 1,        16'h0000, 4'b0000, 1'b1}); // illegal 110
    tbl.push_back('{16'h7ABC, 1,        16'h0000, 4'b0000, 1'b1}); // illegal 111
    tbl.push_back('{16'h8FFF, 2,        16'h0FFF, 4'b0000, 1'b0}); // r0=0xFFF
    tbl.push_back('{16'h5000, EXEC_LAT, 16'h007F, 4'b0000, 1'b0}); // DIV 0xFFF/0x20
    tbl.push_back('{16'h9001, 2,        16'h0001, 4'b0000, 1'b0}); // r1=1
    tbl.push_back('{16'h0000, EXEC_LAT, 16'h1000, 4'b0000, 1'b0}); // ADD
    tbl.push_back('{16'h1000, EXEC_LAT, 16'h0FFE, 4'b1000, 1'b0}); // SUB -> carry
    tbl.push_back('{16'hF800, 2,        16'h0800, 4'b0000, 1'b0}); // r7=0x800

    // reset state
    #12;
    check("reset_outputs", outs, 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("ready_after_reset", 64'(instr_ready), 64'(1));

    foreach (tbl[i]) begin
      send(tbl[i].instr, tbl[i].lat, tbl[i].res, tbl[i].flags, tbl[i].err);
      wait_idle();
    end

    // response stall with a second instruction waiting
    rsp_ready = 1'b0;
    send(16'h0000, EXEC_LAT, 16'h1000, 4'b0000, 1'b0);
    instr_data  = 16'h8123;
    instr_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      check("stall_hold",
            64'({rsp_valid, instr_ready, alu_load, rsp_result, rsp_flags, rsp_err}),
            64'({1'b1, 1'b0, 1'b0, 16'h1000, 4'b0000, 1'b0}));
    end
    rsp_ready = 1'b1;
    send(16'h8123, 2, 16'h0123, 4'b0000, 1'b0);
    wait_idle();

    // reset during EXEC
    start_no_push(16'h0000);
    check("in_exec", 64'(busy), 64'(1));
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_exec_outputs", outs, 64'(0));
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      check("no_rsp_after_exec_abort", 64'({rsp_valid, busy}), 64'(0));
    end

    // reset during LOAD
    start_no_push(16'h8777);
    check("in_load", 64'(alu_load), 64'(1));
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_load_outputs", outs, 64'(0));
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check("no_rsp_after_load_abort", 64'({rsp_valid, busy}), 64'(0));
    end
    send(16'h8005, 2, 16'h0005, 4'b0000, 1'b0);
    wait_idle();

    check("scoreboard_drained", 64'(sb.size()), 64'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule : tb_alu_sequencer
`default_nettype wire
